multi_edge_detector: RTL and testbench

//   Parametrised, multi-channel successor to the single-bit edge detector.

---
 rtl/multi_edge_detector.sv | 116 +++++++++++
 tb/tb_multi_edge_detector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel input synchroniser, debounce filter,
// one-cycle rise/fall pulses, maskable sticky event flags with W1C, and an OR-ed irq.
module multi_edge_detector #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter bit          INIT_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] posEdge,
    output logic [WIDTH-1:0] negEdge,
    output logic [WIDTH-1:0] pending,
    output logic             irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CntOne = CW'(1);

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] neg_q, neg_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             irq_q;

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Input synchroniser chain, one flop per stage per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {WIDTH{INIT_LEVEL}};
            end
        end else begin
            sync_q[0] <= D;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce counters, edge pulses and next pending/irq state.
    always_comb begin
        level_d = level_q;
        pos_d   = '0;
        neg_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    // Disagreement held long enough: accept the new level.
                    level_d[i] = s[i];
                    pos_d[i]   = s[i];
                    neg_d[i]   = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
        // Set is OR-ed after the clear so a coincident set wins.
        pend_d = (pend_q & ~clr) | (pos_d & rise_en) | (neg_d & fall_en);
    end

    // Filter state, pulses, sticky flags and irq registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= {WIDTH{INIT_LEVEL}};
            pos_q   <= '0;
            neg_q   <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            pend_q  <= pend_d;
            irq_q   <= |pend_d;
        end
    end

    assign level   = level_q;
    assign posEdge = pos_q;
    assign negEdge = neg_q;
    assign pending = pend_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters.
module tb_multi_edge_detector;

    logic       clk;
    logic       resetn;
    logic [7:0] D, rise_en, fall_en, clr;
    logic [7:0] level, posEdge, negEdge, pending;
    logic       irq;

    int passed = 0;
    int total  = 0;

    multi_edge_detector dut (
        .clk     (clk),
        .resetn  (resetn),
        .D       (D),
        .rise_en (rise_en),
        .fall_en (fall_en),
        .clr     (clr),
        .level   (level),
        .posEdge (posEdge),
        .negEdge (negEdge),
        .pending (pending),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] ren;
        logic [7:0] fen;
        logic [7:0] clr;
        int         n;
        logic [7:0] lvl;
        logic [7:0] pos;
        logic [7:0] neg;
        logic [7:0] pend;
        logic       irq;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [7:0] d, input logic [7:0] ren, input logic [7:0] fen,
                       input logic [7:0] c, input int n, input logic [7:0] lvl,
                       input logic [7:0] pos, input logic [7:0] neg, input logic [7:0] pend,
                       input logic ir);
        vec_t v;
        v.d = d; v.ren = ren; v.fen = fen; v.clr = c; v.n = n;
        v.lvl = lvl; v.pos = pos; v.neg = neg; v.pend = pend; v.irq = ir;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] lvl, input logic [7:0] pos,
                           input logic [7:0] neg, input logic [7:0] pend, input logic ir);
        chk({tag, " level"}, 32'(level), 32'(lvl));
        chk({tag, " posEdge"}, 32'(posEdge), 32'(pos));
        chk({tag, " negEdge"}, 32'(negEdge), 32'(neg));
        chk({tag, " pending"}, 32'(pending), 32'(pend));
        chk({tag, " irq"}, 32'(irq), 32'(ir));
    endtask

    // D[3] high for len edges, then low; count pulses and level-high cycles on channel 3.
    task automatic glitch(input int len, input int exp_pulses, input int exp_hi);
        int         npos = 0;
        int         nneg = 0;
        int         nhi  = 0;
        logic [7:0] other = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            D = (c < len) ? 8'h08 : 8'h00;
            @(posedge clk);
            #1;
            npos  += int'(posEdge[3]);
            nneg  += int'(negEdge[3]);
            nhi   += int'(level[3]);
            other |= (posEdge | negEdge | level) & 8'hF7;
        end
        chk($sformatf("glitch%0d pos count", len), 32'(npos), 32'(exp_pulses));
        chk($sformatf("glitch%0d neg count", len), 32'(nneg), 32'(exp_pulses));
        chk($sformatf("glitch%0d level hi cycles", len), 32'(nhi), 32'(exp_hi));
        chk($sformatf("glitch%0d other channels", len), 32'(other), 32'h0);
    endtask

    initial begin
        logic [7:0] acc;
        resetn = 1'b1;
        D = 8'h00; rise_en = 8'h00; fall_en = 8'h00; clr = 8'h00;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("in reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        //   d      ren    fen    clr    n   lvl    pos    neg    pend   irq
        add(8'h00, 8'h00, 8'h00, 8'h00, 20, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h00, 8'h00, 8'h00, 5,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h00, 8'h00, 8'h00, 1,  8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h00, 8'h00, 8'h00, 1,  8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h00, 8'h00, 8'h00, 28, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'h00, 8'h00, 5,  8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1,  8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        // Masked pending: ch0 on rise only, ch1 on fall only, then W1C.
        add(8'h03, 8'h01, 8'h02, 8'h00, 5,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h03, 8'h01, 8'h02, 8'h00, 1,  8'h03, 8'h03, 8'h00, 8'h01, 1'b1);
        add(8'h03, 8'h01, 8'h02, 8'h00, 1,  8'h03, 8'h00, 8'h00, 8'h01, 1'b1);
        add(8'h03, 8'h01, 8'h02, 8'h00, 10, 8'h03, 8'h00, 8'h00, 8'h01, 1'b1);
        add(8'h00, 8'h01, 8'h02, 8'h00, 5,  8'h03, 8'h00, 8'h00, 8'h01, 1'b1);
        add(8'h00, 8'h01, 8'h02, 8'h00, 1,  8'h00, 8'h00, 8'h03, 8'h03, 1'b1);
        add(8'h00, 8'h01, 8'h02, 8'h03, 1,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 8'h01, 8'h02, 8'h00, 1,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        // Clear coincident with set: set wins, then flag is sticky, then W1C.
        add(8'h04, 8'h04, 8'h00, 8'h00, 5,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h04, 8'h04, 8'h00, 8'h04, 1,  8'h04, 8'h04, 8'h00, 8'h04, 1'b1);
        add(8'h04, 8'h04, 8'h00, 8'h00, 1,  8'h04, 8'h00, 8'h00, 8'h04, 1'b1);
        add(8'h04, 8'h04, 8'h00, 8'h04, 1,  8'h04, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'h00, 8'h00, 5,  8'h04, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1,  8'h00, 8'h00, 8'h04, 8'h00, 1'b0);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        // All channels rise together.
        add(8'hFF, 8'h00, 8'h00, 8'h00, 5,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'hFF, 8'h00, 8'h00, 8'h00, 1,  8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
        add(8'hFF, 8'h00, 8'h00, 8'h00, 1,  8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'hFF, 8'h00, 8'h00, 8'h00, 4,  8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);

        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            D = vecs[i].d; rise_en = vecs[i].ren; fall_en = vecs[i].fen; clr = vecs[i].clr;
            repeat (vecs[i].n) @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].lvl, vecs[i].pos, vecs[i].neg,
                    vecs[i].pend, vecs[i].irq);
        end

        // Reset asserted mid-debounce of a falling input: outputs clear at once.
        @(negedge clk);
        D = 8'h00; clr = 8'h00;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk_all("async reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        acc = '0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            acc |= posEdge | negEdge | level | pending;
        end
        chk("post-reset quiet", 32'(acc), 32'h0);
        chk("post-reset irq", 32'(irq), 32'h0);

        // Short glitch rejected; glitch of exactly DEBOUNCE cycles accepted.
        glitch(3, 0, 0);
        glitch(4, 1, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
